// File: rtl/regfile_sb_if.sv
// regfile_sb_if
//   Bus bundle between the register file and its client (decode/writeback).
//   Ports carried:
//     rd_addr      NRD packed read indices, port i at [i*ADDR_W +: ADDR_W]
//     rd_data      NRD packed read data (combinational from the slave)
//     rd_busy      scoreboard busy per read port (combinational)
//     wr_en/wr_addr/wr_data  single write port
//     of_control   overflow policy for the write port
//     sb_set/sb_addr         scoreboard set request
//     overflow_err registered trap pulse
//   master: the client side, slave: the register file.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
) ();
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [1:0]            of_control;
  logic                  sb_set;
  logic [ADDR_W-1:0]     sb_addr;
  logic                  overflow_err;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, of_control, sb_set, sb_addr,
    input  rd_data, rd_busy, overflow_err
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, of_control, sb_set, sb_addr,
    output rd_data, rd_busy, overflow_err
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb
//   Multi-port general-purpose register file with per-register scoreboard
//   busy bits and an overflow-flag side channel.
//   Ports:
//     clk  rising-edge clock for all state
//     rst  synchronous active-high reset
//     bus  regfile_sb_if.slave: NRD combinational read ports with write
//          bypass and busy lookup, one write port with overflow policy,
//          scoreboard set port, registered overflow_err pulse.
//   Register 0 is hard-wired to zero and never busy.
module regfile_sb #(
  parameter int              DATA_W   = 32,
  parameter int              ADDR_W   = 5,
  parameter int              NRD      = 2,
  parameter int              GP_IDX   = 28,
  parameter logic [DATA_W-1:0] GP_INIT = 32'h00001800,
  parameter int              SP_IDX   = 29,
  parameter logic [DATA_W-1:0] SP_INIT = 32'h00002ffc,
  parameter int              FLAG_IDX = 30
) (
  input  logic        clk,
  input  logic        rst,
  regfile_sb_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] FLAG_A = ADDR_W'(FLAG_IDX);
  localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic              r_ovf_err;

  logic              w_wr_nz;
  logic              w_trap;
  logic              w_commit;
  logic              w_flag_upd;
  logic [DEPTH-1:0]  w_busy_nxt;

  // A trap suppresses the data write but not the flag update or busy release.
  assign w_wr_nz    = (bus.wr_addr != ZERO_A);
  assign w_trap     = bus.wr_en & (bus.of_control == 2'b11);
  assign w_commit   = bus.wr_en & w_wr_nz & ~(bus.of_control == 2'b11);
  assign w_flag_upd = bus.of_control[1] & w_wr_nz;

  // Register array update: write port first, then flag bit 0 overrides it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == GP_IDX) begin
          r_mem[i] <= GP_INIT;
        end else if (i == SP_IDX) begin
          r_mem[i] <= SP_INIT;
        end else begin
          r_mem[i] <= {DATA_W{1'b0}};
        end
      end
    end else begin
      if (w_commit) begin
        r_mem[bus.wr_addr] <= bus.wr_data;
      end
      if (w_flag_upd) begin
        r_mem[FLAG_A][0] <= bus.of_control[0];
      end
    end
  end

  // Next busy state per register: a new producer (set) beats a retiring one.
  genvar gb;
  generate
    for (gb = 0; gb < DEPTH; gb++) begin : g_busy
      if (gb == 0) begin : g_zero
        assign w_busy_nxt[gb] = 1'b0;
      end else begin : g_nz
        assign w_busy_nxt[gb] =
          (bus.sb_set && (bus.sb_addr == ADDR_W'(gb))) ? 1'b1 :
          (bus.wr_en  && (bus.wr_addr == ADDR_W'(gb))) ? 1'b0 :
          r_busy[gb];
      end
    end
  endgenerate

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= {DEPTH{1'b0}};
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // One-cycle trap pulse; consecutive traps keep it asserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf_err <= 1'b0;
    end else begin
      r_ovf_err <= w_trap;
    end
  end

  assign bus.overflow_err = r_ovf_err;

  // Read ports: zero register, then write bypass, then stored value, with the
  // flag bit patched last so a same-cycle flag update is visible too.
  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_idx;
      logic              w_idx_nz;
      logic [DATA_W-1:0] w_base;
      logic              w_flag_hit;

      assign w_idx      = bus.rd_addr[gi*ADDR_W +: ADDR_W];
      assign w_idx_nz   = (w_idx != ZERO_A);
      assign w_base     = !w_idx_nz                            ? {DATA_W{1'b0}} :
                          (w_commit && (w_idx == bus.wr_addr)) ? bus.wr_data    :
                          r_mem[w_idx];
      assign w_flag_hit = w_flag_upd & w_idx_nz & (w_idx == FLAG_A);

      assign bus.rd_data[gi*DATA_W +: DATA_W] =
        {w_base[DATA_W-1:1], (w_flag_hit ? bus.of_control[0] : w_base[0])};

      // A writeback to the same index this cycle releases the stall early.
      assign bus.rd_busy[gi] = w_idx_nz & r_busy[w_idx] &
                               ~(bus.wr_en & (bus.wr_addr == w_idx));
    end
  endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb
//   Directed bench for regfile_sb. A behavioural model of the register file
//   (plain arrays updated from the architectural rules) is compared against
//   every read port, busy bit and overflow_err on each falling edge; directed
//   steps additionally pin hand-computed literal values.
module tb_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic clk;
  logic rst;
  bit   chk_en;
  int   checks;
  int   errors;

  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) rf_if ();

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (rf_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_mem  [32];
  logic        m_busy [32];
  logic        m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each rising edge from the architectural rules
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 32; k++) begin
        m_mem[k]  <= (k == 28) ? 32'h00001800 : (k == 29) ? 32'h00002ffc : 32'h0;
        m_busy[k] <= 1'b0;
      end
      m_ovf <= 1'b0;
    end else begin
      m_ovf <= rf_if.wr_en && (rf_if.of_control == 2'b11);
      if (rf_if.wr_en && rf_if.wr_addr != 5'd0 && rf_if.of_control != 2'b11)
        m_mem[rf_if.wr_addr] <= rf_if.wr_data;
      if (rf_if.of_control[1] && rf_if.wr_addr != 5'd0)
        m_mem[30][0] <= rf_if.of_control[0];
      if (rf_if.wr_en)
        m_busy[rf_if.wr_addr] <= 1'b0;
      if (rf_if.sb_set && rf_if.sb_addr != 5'd0)
        m_busy[rf_if.sb_addr] <= 1'b1;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    logic [31:0] v;
    logic        commit;
    commit = rf_if.wr_en && rf_if.wr_addr != 5'd0 && rf_if.of_control != 2'b11;
    if (a == 5'd0) return 32'h0;
    v = (commit && a == rf_if.wr_addr) ? rf_if.wr_data : m_mem[a];
    if (rf_if.of_control[1] && rf_if.wr_addr != 5'd0 && a == 5'd30)
      v[0] = rf_if.of_control[0];
    return v;
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    return m_busy[a] && !(rf_if.wr_en && rf_if.wr_addr == a);
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int p = 0; p < NR; p++) begin
        chk($sformatf("model_rd_data%0d", p), rf_if.rd_data[p*DW +: DW],
            exp_rd(rf_if.rd_addr[p*AW +: AW]));
        chk($sformatf("model_rd_busy%0d", p), {31'd0, rf_if.rd_busy[p]},
            {31'd0, exp_busy(rf_if.rd_addr[p*AW +: AW])});
      end
      chk("model_overflow_err", {31'd0, rf_if.overflow_err}, {31'd0, m_ovf});
    end
  end

  task automatic step(input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [1:0] ofc, input logic sbs, input logic [4:0] sa,
                      input logic [4:0] a0, input logic [4:0] a1);
    @(posedge clk);
    #1;
    rf_if.wr_en      = wen;
    rf_if.wr_addr    = wa;
    rf_if.wr_data    = wd;
    rf_if.of_control = ofc;
    rf_if.sb_set     = sbs;
    rf_if.sb_addr    = sa;
    rf_if.rd_addr    = {a1, a0};
    #2;
  endtask

  function automatic logic [31:0] rd0();
    return rf_if.rd_data[31:0];
  endfunction
  function automatic logic [31:0] rd1();
    return rf_if.rd_data[63:32];
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    chk_en = 1'b0;
    rst    = 1'b1;
    rf_if.wr_en = 1'b0; rf_if.wr_addr = 5'd0; rf_if.wr_data = 32'h0;
    rf_if.of_control = 2'b00; rf_if.sb_set = 1'b0; rf_if.sb_addr = 5'd0;
    rf_if.rd_addr = 10'd0;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;

    // Reset values
    step(1'b0, 5'd0, 32'h0, 2'b00, 1'b0, 5'd0, 5'd28, 5'd29);
    chk("reset_r28", rd0(), 32'h00001800);
    chk("reset_r29", rd1(), 32'h00002ffc);
    chk("reset_busy", {30'd0, rf_if.rd_busy}, 32'd0);
    chk("reset_ovf", {31'd0, rf_if.overflow_err}, 32'd0);
    step(1'b0, 5'd0, 32'h0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd5);
    chk("reset_r0", rd0(), 32'h0);
    chk("reset_r5", rd1(), 32'h0);

    // Write with bypass, then stored value, then r0 write ignored
    step(1'b1, 5'd5, 32'hDEADBEEF, 2'b00, 1'b0, 5'd0, 5'd5, 5'd5);
    chk("bypass_r5_p0", rd0(), 32'hDEADBEEF);
    chk("bypass_r5_p1", rd1(), 32'hDEADBEEF);
    step(1'b1, 5'd0, 32'h00001234, 2'b00, 1'b0, 5'd0, 5'd5, 5'd0);
    chk("stored_r5", rd0(), 32'hDEADBEEF);
    chk("r0_write_bypass", rd1(), 32'h0);
    step(1'b0, 5'd0, 32'h0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("r0_after_write", rd0(), 32'h0);

    // Overflow trap on r7
    step(1'b1, 5'd7, 32'h00000055, 2'b11, 1'b0, 5'd0, 5'd7, 5'd30);
    chk("trap_no_bypass", rd0(), 32'h0);
    chk("trap_flag_bypass", rd1(), 32'h1);
    step(1'b0, 5'd0, 32'h0, 2'b00, 1'b0, 5'd0, 5'd7, 5'd30);
    chk("trap_r7_kept", rd0(), 32'h0);
    chk("trap_flag_set", rd1(), 32'h1);
    chk("trap_ovf_pulse", {31'd0, rf_if.overflow_err}, 32'd1);
    step(1'b0, 5'd0, 32'h0, 2'b00, 1'b0, 5'd0, 5'd7, 5'd30);
    chk("trap_ovf_clear", {31'd0, rf_if.overflow_err}, 32'd0);

    // Flag write merge
    step(1'b1, 5'd30, 32'hFFFFFFFF, 2'b10, 1'b0, 5'd0, 5'd30, 5'd0);
    chk("flag_merge_bypass", rd0(), 32'hFFFFFFFE);
    step(1'b0, 5'd0, 32'h0, 2'b00, 1'b0, 5'd0, 5'd30, 5'd0);
    chk("flag_merge_stored", rd0(), 32'hFFFFFFFE);

    // Scoreboard
    step(1'b0, 5'd0, 32'h0, 2'b00, 1'b1, 5'd9, 5'd9, 5'd0);
    chk("sb_set_same_cycle", {31'd0, rf_if.rd_busy[0]}, 32'd0);
    step(1'b0, 5'd0, 32'h0, 2'b00, 1'b0, 5'd0, 5'd9, 5'd0);
    chk("sb_busy_r9", {31'd0, rf_if.rd_busy[0]}, 32'd1);
    step(1'b1, 5'd9, 32'h00000077, 2'b00, 1'b0, 5'd0, 5'd9, 5'd0);
    chk("sb_wb_release", {31'd0, rf_if.rd_busy[0]}, 32'd0);
    chk("sb_wb_data", rd0(), 32'h00000077);
    step(1'b1, 5'd28, 32'h00001111, 2'b00, 1'b0, 5'd0, 5'd9, 5'd28);
    chk("sb_cleared_r9", {31'd0, rf_if.rd_busy[0]}, 32'd0);
    chk("write_r28", rd1(), 32'h00001111);
    step(1'b1, 5'd9, 32'h00000088, 2'b00, 1'b1, 5'd9, 5'd9, 5'd28);
    chk("sb_set_and_wb", rd0(), 32'h00000088);
    step(1'b0, 5'd0, 32'h0, 2'b00, 1'b0, 5'd0, 5'd9, 5'd28);
    chk("sb_set_wins", {31'd0, rf_if.rd_busy[0]}, 32'd1);
    step(1'b0, 5'd0, 32'h0, 2'b00, 1'b1, 5'd0, 5'd0, 5'd9);
    step(1'b0, 5'd0, 32'h0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd9);
    chk("sb_r0_never_busy", {31'd0, rf_if.rd_busy[0]}, 32'd0);
    chk("sb_r9_still_busy", {31'd0, rf_if.rd_busy[1]}, 32'd1);

    // Back-to-back traps
    step(1'b1, 5'd12, 32'h00000099, 2'b11, 1'b0, 5'd0, 5'd12, 5'd30);
    chk("trap2_first_ovf", {31'd0, rf_if.overflow_err}, 32'd0);
    step(1'b1, 5'd12, 32'h00000099, 2'b11, 1'b0, 5'd0, 5'd12, 5'd30);
    chk("trap2_second_ovf", {31'd0, rf_if.overflow_err}, 32'd1);
    step(1'b0, 5'd0, 32'h0, 2'b00, 1'b0, 5'd0, 5'd12, 5'd30);
    chk("trap2_hold_ovf", {31'd0, rf_if.overflow_err}, 32'd1);
    chk("trap2_r12", rd0(), 32'h0);
    chk("trap2_flag", rd1(), 32'hFFFFFFFF);
    step(1'b0, 5'd0, 32'h0, 2'b00, 1'b0, 5'd0, 5'd12, 5'd30);
    chk("trap2_ovf_drop", {31'd0, rf_if.overflow_err}, 32'd0);

    // Flag update without a write enable
    step(1'b0, 5'd5, 32'h0, 2'b10, 1'b0, 5'd0, 5'd30, 5'd5);
    chk("flag_no_wen_bypass", rd0(), 32'hFFFFFFFE);
    chk("flag_no_wen_r5", rd1(), 32'hDEADBEEF);
    step(1'b0, 5'd0, 32'h0, 2'b00, 1'b0, 5'd0, 5'd30, 5'd5);
    chk("flag_no_wen_stored", rd0(), 32'hFFFFFFFE);

    // Reset mid-operation with r9 busy and a pending write to r3
    @(posedge clk);
    #1;
    rst = 1'b1;
    rf_if.wr_en = 1'b1; rf_if.wr_addr = 5'd3; rf_if.wr_data = 32'h00000ABC;
    rf_if.of_control = 2'b00; rf_if.sb_set = 1'b0; rf_if.sb_addr = 5'd0;
    rf_if.rd_addr = {5'd3, 5'd9};
    @(posedge clk);
    #1;
    rst = 1'b0;
    rf_if.wr_en = 1'b0; rf_if.wr_addr = 5'd0; rf_if.wr_data = 32'h0;
    rf_if.rd_addr = {5'd3, 5'd9};
    #2;
    chk("rst_r9_not_busy", {31'd0, rf_if.rd_busy[0]}, 32'd0);
    chk("rst_r3_zero", rd1(), 32'h0);
    step(1'b0, 5'd0, 32'h0, 2'b00, 1'b0, 5'd0, 5'd28, 5'd29);
    chk("rst_r28_restored", rd0(), 32'h00001800);
    chk("rst_r29_restored", rd1(), 32'h00002ffc);
    step(1'b0, 5'd0, 32'h0, 2'b00, 1'b0, 5'd0, 5'd30, 5'd5);
    chk("rst_r30_zero", rd0(), 32'h0);
    chk("rst_r5_zero", rd1(), 32'h0);

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port general-purpose register file with per-register scoreboard busy bits and an overflow-flag side channel. It is the next-generation register file for the MIPS core. It provides NRD combinational read ports with same-cycle write bypass and one synchronous write port. The write port carries the ALU overflow policy. The scoreboard tracks registers with an outstanding producer, such as a load or multi-cycle op, so decode can stall on RAW hazards.

## Interface
- DATA_W, 32: register width
- ADDR_W, 5: register index width; depth = 2^ADDR_W
- NRD, 2: number of read ports (1..4)
- GP_IDX, 28: index reset to GP_INIT
- GP_INIT, 32'h00001800: reset value of GP_IDX
- SP_IDX, 29: index reset to SP_INIT
- SP_INIT, 32'h00002ffc: reset value of SP_IDX
- FLAG_IDX, 30: register whose bit 0 holds the overflow flag

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rd_addr  in  NRD*ADDR_W  read indices; port i occupies bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NRD*DATA_W  read data, combinational
- rd_busy  out  NRD  scoreboard busy for each read index, combinational
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write index
- wr_data  in  DATA_W  write data
- of_control  in  2  overflow control: 2'b11 = overflow trap; 2'b10/2'b11 bit 1 = update flag with bit 0
- sb_set  in  1  mark sb_addr busy (producer issued)
- sb_addr  in  ADDR_W  index to mark busy
- overflow_err  out  1  registered one-cycle pulse on overflow trap

## Operation
- Reset (rst=1 at rising edge):
  - All registers clear to 0, except GP_IDX=GP_INIT and SP_IDX=SP_INIT.
  - All busy bits clear to 0; overflow_err=0.
  - Reset overrides every other input in that cycle.
- Register 0 reads as 0 always, is never written, and is never busy. sb_set with sb_addr=0 is ignored.
- Write commits at the edge when wr_en=1, wr_addr!=0 and of_control!=2'b11.
- Overflow trap, of_control=2'b11 with wr_en=1:
  - Write suppressed.
  - overflow_err=1 for the next cycle only.
  - Busy bit of wr_addr still cleared, because the producer retires.
- Flag update: when of_control[1]=1 and wr_addr!=0, FLAG_IDX[0] <= of_control[0] at the edge, independent of wr_en.
  - If the same edge also writes FLAG_IDX, bits [DATA_W-1:1] take wr_data and bit 0 takes of_control[0].
- Read port i, in priority order:
  - addr 0 → 0.
  - addr==wr_addr with a committing write → wr_data. Trap-suppressed writes are not bypassed.
  - Otherwise the stored value.
  - Final step when a flag update is active and addr==FLAG_IDX: bit 0 is replaced by of_control[0].
- Scoreboard:
  - Busy bit set at the edge by sb_set.
  - Busy bit cleared at the edge by wr_en (committed or trapped) to that index.
  - Set and clear on the same index in the same cycle → set wins, because a new producer is issued.
  - rd_busy[i] = busy[addr] & ~(wr_en & wr_addr==addr), i.e. a same-cycle writeback releases the stall. Always 0 for addr 0.

## Timing
- Read data and rd_busy: zero-latency combinational from rd_addr, wr_*, of_control and the state.
- Write, flag and busy updates: visible one cycle after the edge. Same-cycle visibility is through bypass only.
- overflow_err: asserted the cycle after the trap edge. Back-to-back traps hold it high each cycle.
- Reset mid-operation: pending busy bits and any in-flight write of that cycle are discarded.
- All NRD ports are independent; identical addresses return identical data.

## Test plan
- Reset → read r0=0, r28=32'h1800, r29=32'h2ffc, r5=0; all rd_busy=0; overflow_err=0.
- Write r5=32'hDEADBEEF with read port 0 on r5 in the same cycle → rd_data0=32'hDEADBEEF (bypass); next cycle stored value is the same. Write r0=32'h1234 → r0 still reads 0.
- wr_en, wr_addr=7, wr_data=32'h55, of_control=2'b11 → same-cycle read of r7 returns the old value 0. Next cycle r7=0, overflow_err=1, r30[0]=1. The cycle after, overflow_err=0.
- of_control=2'b10 while writing r30=32'hFFFFFFFF → r30=32'hFFFFFFFE.
- sb_set on r9 → next cycle rd_busy=1 on r9. Writeback to r9 → rd_busy=0 in that same cycle. sb_set and write on r9 together → r9 stays busy.
- rst asserted while r9 busy and a write to r3 is pending → r9 not busy, r3=0, r28/r29 restored.
